alu_decode_stage: RTL and testbench

- Decode pipeline stage: takes RV32I instructions on a valid/ready stream and emits ALU control on a registered valid/ready stream.
- Control outputs: alu_op in the core's 4-bit ALU encoding, operand selects, immediate, register addresses and write enable.
- Sits between fetch and execute; the single producer of alu_op for the execute ALU.
- Flags illegal encodings and counts them.

---
 rtl/alu_decode_stage.sv | 139 +++++++++++++
 tb/tb_alu_decode_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: RV32I decode into ALU control behind a one-slot registered valid/ready stage.
module alu_decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [3:0]       out_alu_op,
  output logic [1:0]       out_a_sel,
  output logic             out_b_imm,
  output logic [31:0]      out_imm,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_rd_we,
  output logic             out_is_branch,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0] op_d;
  logic [1:0] asel_d;
  logic bimm_d, wr_d, br_d, ill_d, we_d, acc;
  logic [31:0] imm_d;
  assign opc = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'd0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  always_comb begin
    op_d = 4'b0000;
    asel_d = 2'b00;
    bimm_d = 1'b1;
    imm_d = imm_i;
    wr_d = 1'b1;
    br_d = 1'b0;
    ill_d = 1'b0;
    case (opc)
      7'b0110011: begin
        op_d = {in_instr[30], f3};
        bimm_d = 1'b0;
        imm_d = '0;
        ill_d = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      7'b0010011: begin
        op_d = {f3 == 3'b101 & in_instr[30], f3};
        imm_d = (f3[1:0] == 2'b01) ? {27'd0, in_instr[24:20]} : imm_i;
        ill_d = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      7'b0110111: begin
        asel_d = 2'b10;
        imm_d = imm_u;
      end
      7'b0010111: begin
        asel_d = 2'b01;
        imm_d = imm_u;
      end
      7'b0000011: ;
      7'b0100011: begin
        imm_d = imm_s;
        wr_d = 1'b0;
      end
      7'b1100011: begin
        br_d = 1'b1;
        bimm_d = 1'b0;
        imm_d = imm_b;
        wr_d = 1'b0;
        op_d = (f3[2:1] == 2'b00) ? 4'b1000 : (f3[2:1] == 2'b10) ? 4'b0010 : 4'b0011;
        ill_d = f3[2:1] == 2'b01;
      end
      7'b1101111: begin
        asel_d = 2'b01;
        imm_d = imm_j;
      end
      7'b1100111: ill_d = f3 != 3'b000;
      default: begin
        bimm_d = 1'b0;
        imm_d = '0;
        wr_d = 1'b0;
        ill_d = 1'b1;
      end
    endcase
    if (ill_d) begin
      op_d = 4'b0000;
      br_d = 1'b0;
    end
  end
  assign we_d = wr_d & (in_instr[11:7] != 5'd0) & !ill_d;
  assign in_ready = !out_valid | out_ready;
  assign acc = in_valid & in_ready & !flush;
  // Fields load only on accept, so a stalled bundle stays bit-stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc <= '0;
      out_alu_op <= '0;
      out_a_sel <= '0;
      out_b_imm <= 1'b0;
      out_imm <= '0;
      out_rs1 <= '0;
      out_rs2 <= '0;
      out_rd <= '0;
      out_rd_we <= 1'b0;
      out_is_branch <= 1'b0;
      out_illegal <= 1'b0;
      illegal_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_pc <= in_pc;
      out_alu_op <= op_d;
      out_a_sel <= asel_d;
      out_b_imm <= bimm_d;
      out_imm <= imm_d;
      out_rs1 <= in_instr[19:15];
      out_rs2 <= in_instr[24:20];
      out_rd <= in_instr[11:7];
      out_rd_we <= we_d;
      out_is_branch <= br_d;
      out_illegal <= ill_d;
      if (ill_d && !(&illegal_cnt)) illegal_cnt <= illegal_cnt + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed vectors checked against a spec-level decode model every cycle.
module tb_alu_decode_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  op;
    logic [1:0]  asel;
    logic        bimm;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        we, br, ill;
  } bundle_t;
  localparam logic [31:0] SUB  = 32'h402081B3, SRAI = 32'h40335293, BLTU = 32'hFE20EEE3;
  localparam logic [31:0] ILL  = 32'h4020F1B3, ADD  = 32'h003100B3, XOR  = 32'h0020C233;
  localparam logic [31:0] LUI  = 32'h123450B7, JAL  = 32'h008000EF;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0, run = 0;
  logic [31:0] in_instr = 0, in_pc = 32'h1000;
  logic in_ready, out_valid, out_b_imm, out_rd_we, out_is_branch, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [3:0] out_alu_op;
  logic [1:0] out_a_sel;
  logic [4:0] out_rs1, out_rs2, out_rd;
  logic [15:0] illegal_cnt;
  logic s_in_ready, s_out_valid, s_b_imm, s_rd_we, s_br, s_ill;
  logic [31:0] s_pc, s_imm;
  logic [3:0] s_op;
  logic [1:0] s_asel, s_cnt;
  logic [4:0] s_rs1, s_rs2, s_rd;
  int checks = 0, errors = 0, cnt16 = 0, cnt2 = 0;
  bundle_t eb;
  logic ev = 0;
  alu_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_alu_op(out_alu_op), .out_a_sel(out_a_sel), .out_b_imm(out_b_imm),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_is_branch(out_is_branch), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt));
  alu_decode_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pc(s_pc), .out_alu_op(s_op), .out_a_sel(s_asel), .out_b_imm(s_b_imm),
    .out_imm(s_imm), .out_rs1(s_rs1), .out_rs2(s_rs2), .out_rd(s_rd),
    .out_rd_we(s_rd_we), .out_is_branch(s_br), .out_illegal(s_ill), .illegal_cnt(s_cnt));
  always #5 clk = ~clk;
  function automatic bundle_t model(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t b;
    logic [2:0] f3;
    logic [6:0] f7;
    logic wr;
    logic signed [31:0] sx;
    b = '0;
    b.pc = pc;
    b.rs1 = ins[19:15];
    b.rs2 = ins[24:20];
    b.rd = ins[11:7];
    f3 = ins[14:12];
    f7 = ins[31:25];
    sx = $signed(ins);
    wr = 1'b1;
    case (ins[6:0])
      7'h33: begin
        b.op = {ins[30], f3};
        b.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'h13: begin
        b.bimm = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          b.imm = {27'd0, ins[24:20]};
          b.op = {(f3 == 3'd5) ? ins[30] : 1'b0, f3};
          b.ill = f7 != 7'h00 && !(f3 == 3'd5 && f7 == 7'h20);
        end else begin
          b.imm = sx >>> 20;
          b.op = {1'b0, f3};
        end
      end
      7'h37: begin b.asel = 2'd2; b.bimm = 1'b1; b.imm = ins & 32'hFFFFF000; end
      7'h17: begin b.asel = 2'd1; b.bimm = 1'b1; b.imm = ins & 32'hFFFFF000; end
      7'h03: begin b.bimm = 1'b1; b.imm = sx >>> 20; end
      7'h23: begin
        b.bimm = 1'b1;
        b.imm = ((sx >>> 20) & ~32'h1F) | {27'd0, ins[11:7]};
        wr = 1'b0;
      end
      7'h63: begin
        b.br = 1'b1;
        wr = 1'b0;
        b.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        case (f3)
          3'd0, 3'd1: b.op = 4'b1000;
          3'd4, 3'd5: b.op = 4'b0010;
          3'd6, 3'd7: b.op = 4'b0011;
          default: b.ill = 1'b1;
        endcase
      end
      7'h6F: begin
        b.asel = 2'd1;
        b.bimm = 1'b1;
        b.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'h67: begin b.bimm = 1'b1; b.imm = sx >>> 20; b.ill = f3 != 3'd0; end
      default: b.ill = 1'b1;
    endcase
    if (b.ill) begin b.op = 4'd0; b.br = 1'b0; end
    b.we = wr && ins[11:7] != 5'd0 && !b.ill;
    return b;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ev <= 1'b0;
      eb <= '0;
      cnt16 <= 0;
      cnt2 <= 0;
    end else if (flush) begin
      ev <= 1'b0;
    end else if (in_valid && (!ev || out_ready)) begin
      ev <= 1'b1;
      eb <= model(in_instr, in_pc);
      if (model(in_instr, in_pc).ill) begin
        cnt16 <= (cnt16 < 65535) ? cnt16 + 1 : cnt16;
        cnt2 <= (cnt2 < 3) ? cnt2 + 1 : cnt2;
      end
    end else if (out_ready) begin
      ev <= 1'b0;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (run && !rst) begin
      chk("in_ready", 32'(in_ready), 32'(!ev || out_ready));
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("cnt16", 32'(illegal_cnt), 32'(cnt16));
      chk("cnt2", 32'(s_cnt), 32'(cnt2));
      if (ev) begin
        chk("pc", out_pc, eb.pc);
        chk("alu_op", 32'(out_alu_op), 32'(eb.op));
        chk("rs1", 32'(out_rs1), 32'(eb.rs1));
        chk("rs2", 32'(out_rs2), 32'(eb.rs2));
        chk("rd", 32'(out_rd), 32'(eb.rd));
        chk("rd_we", 32'(out_rd_we), 32'(eb.we));
        chk("is_branch", 32'(out_is_branch), 32'(eb.br));
        chk("illegal", 32'(out_illegal), 32'(eb.ill));
        if (!eb.ill) begin
          chk("a_sel", 32'(out_a_sel), 32'(eb.asel));
          chk("b_imm", 32'(out_b_imm), 32'(eb.bimm));
          chk("imm", out_imm, eb.imm);
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic issue(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc = in_pc + 4;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    #1;
  endtask
  task automatic stream(input logic rnd);
    logic [31:0] tab [16];
    tab = '{32'h00001117, 32'hFFC12183, 32'h00312223, 32'h00208463, 32'h000080E7,
            32'h000090E7, 32'h00209093, 32'h40209093, 32'h0020A1B3, 32'h00002063,
            32'h00100013, 32'hFFF0C293, 32'h0020D1B3, 32'h4020D1B3, 32'h800000EF, SUB};
    for (int i = 0; i < 16; i++) begin
      int n = 0;
      logic acc = 1'b0;
      in_valid = 1'b1;
      in_instr = tab[i];
      in_pc = in_pc + 4;
      while (!acc && n < 20) begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #2;
        n++;
      end
      if (!acc) begin
        errors++;
        $display("FAIL accept_timeout: got no accept after %0d cycles, required accept", n);
      end
      if (!rnd) chk("throughput_cycles", 32'(n), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
  endtask
  initial begin
    logic [31:0] snap_pc, snap_imm, pc_b;
    logic [15:0] cnt_before;
    #1 rst = 1'b1;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_op", 32'(out_alu_op), 32'd0);
    chk("rst_cnt", 32'(illegal_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    run = 1'b1;
    out_ready = 1'b1;
    issue(SUB);
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_op", 32'(out_alu_op), 32'h8);
    chk("sub_regs", {17'd0, out_rs1, out_rs2, out_rd}, {17'd0, 5'd1, 5'd2, 5'd3});
    chk("sub_we_bimm", {30'd0, out_rd_we, out_b_imm}, 32'd2);
    issue(SRAI);
    chk("srai_op", 32'(out_alu_op), 32'hD);
    chk("srai_imm", out_imm, 32'h3);
    chk("srai_rd_we_bimm", {25'd0, out_rd, out_rd_we, out_b_imm}, {25'd0, 5'd5, 2'b11});
    issue(BLTU);
    chk("bltu_op", 32'(out_alu_op), 32'h3);
    chk("bltu_imm", out_imm, 32'hFFFFFFFC);
    chk("bltu_br_we", {30'd0, out_is_branch, out_rd_we}, 32'd2);
    issue(LUI);
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_asel", 32'(out_a_sel), 32'd2);
    issue(JAL);
    chk("jal_imm_asel", {out_imm[29:0], out_a_sel}, {30'd8, 2'd1});
    issue(ILL);
    chk("ill_flag_op_we", {27'd0, out_illegal, out_alu_op, out_rd_we}, {27'd0, 1'b1, 4'd0, 1'b0});
    chk("ill_cnt1", 32'(illegal_cnt), 32'd1);
    issue(32'h00000000);
    issue(32'hFFFFFFFF);
    issue(ILL);
    chk("cnt16_four", 32'(illegal_cnt), 32'd4);
    chk("cnt2_saturated", 32'(s_cnt), 32'd3);
    step();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = ADD;
    in_pc = in_pc + 4;
    step();
    in_instr = XOR;
    in_pc = in_pc + 4;
    pc_b = in_pc;
    @(negedge clk);
    #1;
    snap_pc = out_pc;
    snap_imm = out_imm;
    chk("bp_first_rd", 32'(out_rd), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_pc", out_pc, snap_pc);
      chk("bp_hold_rd_op", {23'd0, out_rd, out_alu_op}, {23'd0, 5'd1, 4'd0});
      chk("bp_hold_imm", out_imm, snap_imm);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("bp_second_rd_op", {23'd0, out_rd, out_alu_op}, {23'd0, 5'd4, 4'd4});
    chk("bp_second_pc", out_pc, pc_b);
    cnt_before = illegal_cnt;
    in_valid = 1'b1;
    in_instr = ILL;
    flush = 1'b1;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    #1;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_cnt", 32'(illegal_cnt), 32'(cnt_before));
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = ADD;
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    #1;
    chk("flush_held", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    stream(1'b0);
    stream(1'b1);
    in_valid = 1'b1;
    in_instr = ILL;
    step();
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_cnt", 32'(illegal_cnt), 32'd0);
    chk("midrst_cnt2", 32'(s_cnt), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    step();
    issue(SUB);
    chk("post_rst_op", 32'(out_alu_op), 32'h8);
    chk("post_rst_cnt", 32'(illegal_cnt), 32'd0);
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
